// File: rtl/fcp_sink_filter_if.sv
// ---------------------------------------------------------------------------
// fcp_sink_filter_if
//   Bundles the two handshake buses of the FCP sink filter:
//     s_axis_fcp_*  : single-beat FCP credit updates coming in (AXI-Stream)
//     m_fcp_*       : unpacked, filtered updates going to the credit scheduler
//   Modports:
//     slave  : the filter side (consumes the stream, produces m_fcp_*)
//     master : the environment side (produces the stream, consumes m_fcp_*)
// ---------------------------------------------------------------------------
interface fcp_sink_filter_if #(
  parameter int AXIS_WIDTH        = 512,
  parameter int QUEUE_INDEX_WIDTH = 15,
  parameter int STAT_WIDTH        = 32
);
  logic [AXIS_WIDTH-1:0]        s_axis_fcp_tdata;
  logic                         s_axis_fcp_tvalid;
  logic                         s_axis_fcp_tready;

  logic                         m_fcp_valid;
  logic                         m_fcp_ready;
  logic [QUEUE_INDEX_WIDTH-1:0] m_fcp_vc;
  logic [STAT_WIDTH-1:0]        m_fcp_fccl;
  logic [STAT_WIDTH-1:0]        m_fcp_qlen;
  logic [STAT_WIDTH-1:0]        m_fcp_fccr;

  modport slave (
    input  s_axis_fcp_tdata, s_axis_fcp_tvalid, m_fcp_ready,
    output s_axis_fcp_tready, m_fcp_valid, m_fcp_vc, m_fcp_fccl, m_fcp_qlen, m_fcp_fccr
  );

  modport master (
    output s_axis_fcp_tdata, s_axis_fcp_tvalid, m_fcp_ready,
    input  s_axis_fcp_tready, m_fcp_valid, m_fcp_vc, m_fcp_fccl, m_fcp_qlen, m_fcp_fccr
  );
endinterface

// File: rtl/fcp_sink_filter.sv
// ---------------------------------------------------------------------------
// fcp_sink_filter
//   Receives single-beat FCP credit updates, queues the VC/FCCL/QLEN/FCCR
//   fields in a small FIFO, drops updates whose VC is out of range or whose
//   FCCL is older than the last accepted FCCL for that VC (wrap-aware), and
//   presents the survivors on a registered valid/ready output.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   fcp (slave)         s_axis_fcp_* input stream, m_fcp_* output updates
//   cfg_stale_chk_en    1 = drop stale FCCL updates
//   stat_accepted       saturating count of forwarded updates
//   stat_drop_bad_vc    saturating count of out-of-range VC drops
//   stat_drop_stale     saturating count of stale FCCL drops
// ---------------------------------------------------------------------------
module fcp_sink_filter #(
  parameter int QUEUE_INDEX_WIDTH = 15,
  parameter int NUM_VC            = 32,
  parameter int STAT_WIDTH        = 32,
  parameter int AXIS_WIDTH        = 512,
  parameter int FIFO_DEPTH        = 4,
  parameter int FCCL_OFFSET       = 0,
  parameter int QLEN_OFFSET       = 32,
  parameter int FCCR_OFFSET       = 64,
  parameter int VC_OFFSET         = 96,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  fcp_sink_filter_if.slave     fcp,
  input  logic                 cfg_stale_chk_en,
  output logic [CNT_WIDTH-1:0] stat_accepted,
  output logic [CNT_WIDTH-1:0] stat_drop_bad_vc,
  output logic [CNT_WIDTH-1:0] stat_drop_stale
);

  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int VC_IDX_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

  typedef struct packed {
    logic [QUEUE_INDEX_WIDTH-1:0] vc;
    logic [STAT_WIDTH-1:0]        fccl;
    logic [STAT_WIDTH-1:0]        qlen;
    logic [STAT_WIDTH-1:0]        fccr;
  } entry_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // -------------------------------------------------------------------------
  // Input FIFO (combinational head read so the check stage sees it at once)
  // -------------------------------------------------------------------------
  entry_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;

  entry_t in_entry;
  entry_t head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   push;
  logic   pop;

  // Bits of tdata outside the four fields are intentionally ignored.
  logic unused_tdata;
  assign unused_tdata = ^fcp.s_axis_fcp_tdata;

  assign in_entry.vc   = fcp.s_axis_fcp_tdata[VC_OFFSET   +: QUEUE_INDEX_WIDTH];
  assign in_entry.fccl = fcp.s_axis_fcp_tdata[FCCL_OFFSET +: STAT_WIDTH];
  assign in_entry.qlen = fcp.s_axis_fcp_tdata[QLEN_OFFSET +: STAT_WIDTH];
  assign in_entry.fccr = fcp.s_axis_fcp_tdata[FCCR_OFFSET +: STAT_WIDTH];

  // tready depends only on the registered occupancy, never on m_fcp_ready.
  assign fifo_full  = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign fcp.s_axis_fcp_tready = !fifo_full;
  assign push = fcp.s_axis_fcp_tvalid && !fifo_full;
  assign head = fifo_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Check stage on the FIFO head
  // -------------------------------------------------------------------------
  logic                  m_valid_reg;
  entry_t                m_data_reg;
  logic [STAT_WIDTH-1:0] last_fccl_reg [NUM_VC];
  logic                  seen_reg      [NUM_VC];

  logic                  check_en;
  logic [VC_IDX_W-1:0]   head_idx;
  logic                  bad_vc;
  logic [STAT_WIDTH-1:0] fccl_delta;
  logic                  stale;
  logic                  accept;

  // The head is examined whenever the output register can take a new update.
  assign check_en = !m_valid_reg || fcp.m_fcp_ready;
  assign pop      = check_en && !fifo_empty;

  assign head_idx   = head.vc[VC_IDX_W-1:0];
  assign bad_vc     = ({{(32-QUEUE_INDEX_WIDTH){1'b0}}, head.vc} >= NUM_VC);
  // Modular difference: MSB set means the new FCCL is behind the last one.
  assign fccl_delta = head.fccl - last_fccl_reg[head_idx];
  assign stale      = !bad_vc && cfg_stale_chk_en && seen_reg[head_idx] &&
                      fccl_delta[STAT_WIDTH-1];
  assign accept     = pop && !bad_vc && !stale;

  // Per-VC table; a write lands before the next cycle's check reads it.
  generate
    for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc_table
      always_ff @(posedge clk) begin
        if (rst) begin
          last_fccl_reg[gi] <= '0;
          seen_reg[gi]      <= 1'b0;
        end else if (accept && (head_idx == VC_IDX_W'(gi))) begin
          last_fccl_reg[gi] <= head.fccl;
          seen_reg[gi]      <= 1'b1;
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Output register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
    end else if (check_en) begin
      m_valid_reg <= accept;
      if (accept) m_data_reg <= head;
    end
  end

  assign fcp.m_fcp_valid = m_valid_reg;
  assign fcp.m_fcp_vc    = m_data_reg.vc;
  assign fcp.m_fcp_fccl  = m_data_reg.fccl;
  assign fcp.m_fcp_qlen  = m_data_reg.qlen;
  assign fcp.m_fcp_fccr  = m_data_reg.fccr;

  // -------------------------------------------------------------------------
  // Statistics
  // -------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] acc_cnt_reg;
  logic [CNT_WIDTH-1:0] bad_cnt_reg;
  logic [CNT_WIDTH-1:0] stale_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt_reg   <= '0;
      bad_cnt_reg   <= '0;
      stale_cnt_reg <= '0;
    end else begin
      if (accept)         acc_cnt_reg   <= sat_inc(acc_cnt_reg);
      if (pop && bad_vc)  bad_cnt_reg   <= sat_inc(bad_cnt_reg);
      if (pop && stale)   stale_cnt_reg <= sat_inc(stale_cnt_reg);
    end
  end

  assign stat_accepted    = acc_cnt_reg;
  assign stat_drop_bad_vc = bad_cnt_reg;
  assign stat_drop_stale  = stale_cnt_reg;

endmodule

// File: tb/tb_fcp_sink_filter.sv
// ---------------------------------------------------------------------------
// tb_fcp_sink_filter
//   Directed scenarios plus randomized traffic for fcp_sink_filter, checked
//   against a transaction-level model (expected-output queue, per-VC table).
// ---------------------------------------------------------------------------
module tb_fcp_sink_filter;
  localparam int QIW    = 15;
  localparam int NUM_VC = 32;
  localparam int SW     = 32;
  localparam int AW     = 512;
  localparam int DEPTH  = 4;
  localparam int CW     = 32;

  logic clk = 0;
  logic rst = 1;
  logic cfg = 1;
  logic fixed_ready = 0;
  logic rand_ready = 0;
  logic rand_mode = 0;
  logic [CW-1:0] stat_accepted, stat_drop_bad_vc, stat_drop_stale;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fcp_sink_filter_if #(.AXIS_WIDTH(AW), .QUEUE_INDEX_WIDTH(QIW), .STAT_WIDTH(SW)) bus ();

  assign bus.m_fcp_ready = rand_mode ? rand_ready : fixed_ready;

  fcp_sink_filter #(
    .QUEUE_INDEX_WIDTH(QIW), .NUM_VC(NUM_VC), .STAT_WIDTH(SW), .AXIS_WIDTH(AW),
    .FIFO_DEPTH(DEPTH), .FCCL_OFFSET(0), .QLEN_OFFSET(32), .FCCR_OFFSET(64),
    .VC_OFFSET(96), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fcp(bus.slave),
    .cfg_stale_chk_en(cfg),
    .stat_accepted(stat_accepted),
    .stat_drop_bad_vc(stat_drop_bad_vc),
    .stat_drop_stale(stat_drop_stale)
  );

  always @(posedge clk) begin
    #1 rand_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned vc;
    logic [31:0] fccl;
    logic [31:0] qlen;
    logic [31:0] fccr;
  } upd_t;

  upd_t        exp_q[$];
  logic [31:0] m_last [NUM_VC];
  bit          m_seen [NUM_VC];
  int          m_acc = 0, m_bad = 0, m_stale = 0;

  function automatic void model_clear();
    exp_q.delete();
    for (int i = 0; i < NUM_VC; i++) begin
      m_last[i] = 0;
      m_seen[i] = 0;
    end
    m_acc = 0;
    m_bad = 0;
    m_stale = 0;
  endfunction

  function automatic void model_push(input int unsigned vc, input logic [31:0] fccl,
                                     input logic [31:0] qlen, input logic [31:0] fccr);
    upd_t u;
    int   diff;
    if (vc >= NUM_VC) begin
      m_bad++;
      return;
    end
    diff = int'(fccl - m_last[vc]);
    if (m_seen[vc] && cfg && diff < 0) begin
      m_stale++;
      return;
    end
    u.vc = vc; u.fccl = fccl; u.qlen = qlen; u.fccr = fccr;
    exp_q.push_back(u);
    m_last[vc] = fccl;
    m_seen[vc] = 1;
    m_acc++;
  endfunction

  // ---------------- output monitor ----------------
  logic        stall_prev = 0;
  logic [31:0] saved_vc, saved_fccl, saved_qlen, saved_fccr;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 64'(bus.m_fcp_valid), 64'd1);
        check("hold_vc",    64'(bus.m_fcp_vc),    64'(saved_vc));
        check("hold_fccl",  64'(bus.m_fcp_fccl),  64'(saved_fccl));
        check("hold_fccr",  64'(bus.m_fcp_fccr),  64'(saved_fccr));
      end
      if (bus.m_fcp_valid && bus.m_fcp_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          upd_t e;
          e = exp_q.pop_front();
          $display("out vc=%0d fccl=%08h qlen=%08h fccr=%08h", bus.m_fcp_vc, bus.m_fcp_fccl,
                   bus.m_fcp_qlen, bus.m_fcp_fccr);
          check("out_vc",   64'(bus.m_fcp_vc),   64'(e.vc));
          check("out_fccl", 64'(bus.m_fcp_fccl), 64'(e.fccl));
          check("out_qlen", 64'(bus.m_fcp_qlen), 64'(e.qlen));
          check("out_fccr", 64'(bus.m_fcp_fccr), 64'(e.fccr));
        end
      end
      stall_prev = bus.m_fcp_valid && !bus.m_fcp_ready;
      saved_vc   = 32'(bus.m_fcp_vc);
      saved_fccl = bus.m_fcp_fccl;
      saved_qlen = bus.m_fcp_qlen;
      saved_fccr = bus.m_fcp_fccr;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_beat(input int unsigned vc, input logic [31:0] fccl,
                            input logic [31:0] qlen, input logic [31:0] fccr);
    logic [AW-1:0] d;
    d = {16{$urandom()}};
    d[0 +: 32]  = fccl;
    d[32 +: 32] = qlen;
    d[64 +: 32] = fccr;
    d[96 +: QIW] = QIW'(vc);
    bus.s_axis_fcp_tdata  = d;
    bus.s_axis_fcp_tvalid = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int unsigned vc, input logic [31:0] fccl,
                      input logic [31:0] qlen, input logic [31:0] fccr);
    bit done = 0;
    int n = 0;
    drive_beat(vc, fccl, qlen, fccr);
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      if (bus.s_axis_fcp_tready) begin
        model_push(vc, fccl, qlen, fccr);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
    bus.s_axis_fcp_tvalid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    bus.s_axis_fcp_tvalid = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || bus.m_fcp_valid) && n < 400);
    if (n >= 400) check({tag, "_drain_timeout"}, 64'(exp_q.size()), 64'd0);
    repeat (DEPTH + 3) @(negedge clk);
    check({tag, "_accepted"}, 64'(stat_accepted),    64'(m_acc));
    check({tag, "_bad_vc"},   64'(stat_drop_bad_vc), 64'(m_bad));
    check({tag, "_stale"},    64'(stat_drop_stale),  64'(m_stale));
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int i;
    logic [31:0] f;
    int unsigned v;

    bus.s_axis_fcp_tdata  = '0;
    bus.s_axis_fcp_tvalid = 1'b0;
    model_clear();

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(bus.m_fcp_valid), 64'd0);
    check("rst_acc",   64'(stat_accepted),   64'd0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("post_rst_tready", 64'(bus.s_axis_fcp_tready), 64'd1);
    check("post_rst_valid",  64'(bus.m_fcp_valid),       64'd0);
    check("post_rst_stale",  64'(stat_drop_stale),       64'd0);
    @(posedge clk);
    #1;

    // T1: single update, 2-cycle latency
    fixed_ready = 1;
    send(3, 32'd100, 32'h11, 32'h22);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.m_fcp_valid && n < 10);
    check("t1_latency", 64'(n), 64'd2);
    @(posedge clk);
    #1;
    wait_idle("t1");

    // T2: out-of-range VC dropped; VC 8 (aliases 40 in low bits) stays unseen
    send(40, 32'd1000, 32'd0, 32'd0);
    send(8, 32'd1, 32'd2, 32'd3);
    wait_idle("t2");

    // T3: stale drop, then the same pair with the check disabled
    send(5, 32'd200, 32'd0, 32'd0);
    send(5, 32'd150, 32'd0, 32'd0);
    wait_idle("t3a");
    cfg = 0;
    send(5, 32'd200, 32'd0, 32'd0);
    send(5, 32'd150, 32'd0, 32'd0);
    wait_idle("t3b");
    cfg = 1;

    // T4: FCCL wrap
    send(1, 32'hFFFF_FFF0, 32'd0, 32'd0);
    send(1, 32'h0000_0010, 32'd0, 32'd0);
    wait_idle("t4");

    // T5: backpressure, 4 in FIFO + 1 in output register
    fixed_ready = 0;
    i = 0;
    drive_beat(10, 32'd1000, 32'd0, 32'd0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.s_axis_fcp_tvalid && bus.s_axis_fcp_tready) begin
        model_push(10, 32'(1000 + i), 32'(i), 32'd0);
        i++;
      end
      @(posedge clk);
      #1;
      if (i < 6) drive_beat(10, 32'(1000 + i), 32'(i), 32'd0);
    end
    @(negedge clk);
    check("t5_accepts", 64'(i), 64'd5);
    check("t5_tready",  64'(bus.s_axis_fcp_tready), 64'd0);
    check("t5_head",    64'(bus.m_fcp_fccl), 64'd1000);
    @(posedge clk);
    #1;
    bus.s_axis_fcp_tvalid = 1'b0;
    fixed_ready = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t5_b2b_valid", 64'(bus.m_fcp_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    wait_idle("t5");

    // T6: reset with updates in flight
    fixed_ready = 0;
    send(3, 32'd101, 32'd0, 32'd0);
    send(3, 32'd102, 32'd0, 32'd0);
    send(3, 32'd103, 32'd0, 32'd0);
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_clear();
    fixed_ready = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t6_no_valid", 64'(bus.m_fcp_valid), 64'd0);
    end
    check("t6_acc_zero",   64'(stat_accepted),   64'd0);
    check("t6_stale_zero", 64'(stat_drop_stale), 64'd0);
    @(posedge clk);
    #1;
    send(3, 32'd5, 32'd0, 32'd0);
    wait_idle("t6");

    // Randomized traffic with random consumer backpressure
    rand_mode = 1;
    for (int b = 0; b < 4; b++) begin
      cfg = b[0];
      for (int t = 0; t < 60; t++) begin
        if ($urandom_range(0, 9) == 0) v = $urandom_range(NUM_VC, 32767);
        else v = $urandom_range(0, 7);
        if (v < NUM_VC && m_seen[v] && $urandom_range(0, 3) != 0)
          f = m_last[v] + 32'($urandom_range(0, 40)) - 32'd20;
        else
          f = $urandom();
        send(v, f, $urandom(), $urandom());
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      wait_idle("rand");
    end
    rand_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=1 expected=0");
    $fatal(1, "timeout");
  end

endmodule
